// File: rtl/vga_pkg.sv
// vga_pkg: 640x480 timing constants, counter width and FSM
// states shared by the VGA sync monitor and its helpers.
package vga_pkg;

  localparam int CNT_W = 11;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  localparam int H_SYNC  = 96;
  localparam int H_BP    = 48;
  localparam int H_ACT   = 640;
  localparam int H_FP    = 16;
  localparam int H_TOTAL = H_SYNC + H_BP + H_ACT + H_FP;

  localparam int V_SYNC  = 2;
  localparam int V_BP    = 33;
  localparam int V_ACT   = 480;
  localparam int V_FP    = 10;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACT + V_FP;

  typedef enum logic [1:0] {
    SEARCH,
    MEASURE,
    LOCKED
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: strobe-qualified falling-edge detector.
// Ports: clk, rst (sync, high), en (strobe), sync (level), fall (pulse).
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic sync,
  output logic fall
);

  logic prev;

  // Idle level of an active-low sync is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev <= 1'b1;
    end else if (en) begin
      prev <= sync;
    end
  end

  assign fall = en & prev & ~sync;

endmodule

// File: rtl/vga_sync_monitor.sv
// vga_sync_monitor: measures HS/VS timing, locks on stable frames,
// recovers x/y and active flag, pulses o_err on lock loss/timeout.
// Ports: clk, rst, pix_en, i_hs, i_vs in; o_locked, o_active, o_x,
// o_y, o_line_len, o_frame_lines, o_err out.
module vga_sync_monitor
  import vga_pkg::*;
#(
  parameter int HS_TO_ACTIVE = H_SYNC + H_BP,
  parameter int H_ACTIVE     = H_ACT,
  parameter int VS_TO_ACTIVE = V_SYNC + V_BP,
  parameter int V_ACTIVE     = V_ACT,
  parameter int LOCK_FRAMES  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_en,
  input  logic             i_hs,
  input  logic             i_vs,
  output logic             o_locked,
  output logic             o_active,
  output logic [9:0]       o_x,
  output logic [9:0]       o_y,
  output logic [CNT_W-1:0] o_line_len,
  output logic [CNT_W-1:0] o_frame_lines,
  output logic             o_err
);

  localparam logic [CNT_W-1:0] H_LO =
    CNT_W'(HS_TO_ACTIVE);
  localparam logic [CNT_W-1:0] H_HI =
    CNT_W'(HS_TO_ACTIVE + H_ACTIVE);
  localparam logic [CNT_W-1:0] V_LO =
    CNT_W'(VS_TO_ACTIVE);
  localparam logic [CNT_W-1:0] V_HI =
    CNT_W'(VS_TO_ACTIVE + V_ACTIVE);
  localparam logic [2:0] LOCK_LAST =
    3'(LOCK_FRAMES - 1);

  logic hs_fall, vs_fall;

  state_t state, state_nx;

  logic [CNT_W-1:0] h_cnt, h_nx;
  logic [CNT_W-1:0] v_cnt, v_nx;
  logic [CNT_W-1:0] line_len, line_nx;
  logic [CNT_W-1:0] frame_lines, frame_nx;
  logic [CNT_W-1:0] first_len, first_nx;
  logic             first_seen, seen_nx;
  logic             line_bad, bad_nx;
  logic [2:0]       match_cnt, match_nx, match_inc;
  logic             err, err_nx;

  logic [CNT_W-1:0] meas_len, meas_frame, frame_len;
  logic             len_dev, bad_now, good;
  logic             hact, vact;

  sync_edge_det u_hs (
    .clk  (clk),
    .rst  (rst),
    .en   (pix_en),
    .sync (i_hs),
    .fall (hs_fall)
  );

  sync_edge_det u_vs (
    .clk  (clk),
    .rst  (rst),
    .en   (pix_en),
    .sync (i_vs),
    .fall (vs_fall)
  );

  assign meas_len = sat_inc(h_cnt);

  // A coincident HS edge closes the ending frame.
  assign meas_frame =
    hs_fall ? sat_inc(v_cnt) : v_cnt;

  assign frame_len =
    first_seen ? first_len : meas_len;
  assign len_dev =
    first_seen & (meas_len != first_len);
  assign bad_now = line_bad | (hs_fall & len_dev);
  assign good =
    ~bad_now & (frame_len == line_len);
  assign match_inc = match_cnt + 3'd1;

  always_comb begin
    state_nx = state;
    h_nx     = h_cnt;
    v_nx     = v_cnt;
    line_nx  = line_len;
    frame_nx = frame_lines;
    first_nx = first_len;
    seen_nx  = first_seen;
    bad_nx   = line_bad;
    match_nx = match_cnt;
    err_nx   = 1'b0;
    if (pix_en) begin
      h_nx = hs_fall ? '0 : sat_inc(h_cnt);
      if (vs_fall) begin
        v_nx = '0;
      end else if (hs_fall) begin
        v_nx = sat_inc(v_cnt);
      end
      if (vs_fall) begin
        seen_nx = 1'b0;
        bad_nx  = 1'b0;
      end else if (hs_fall) begin
        if (!first_seen) begin
          seen_nx  = 1'b1;
          first_nx = meas_len;
        end else if (len_dev) begin
          bad_nx = 1'b1;
        end
      end
      unique case (state)
        SEARCH: begin
          if (vs_fall) begin
            state_nx = MEASURE;
            match_nx = '0;
          end
        end
        MEASURE: begin
          if (vs_fall) begin
            if (good &&
                meas_frame == frame_lines) begin
              match_nx = match_inc;
              if (match_inc >= LOCK_LAST) begin
                state_nx = LOCKED;
              end
            end else begin
              line_nx  = frame_len;
              frame_nx = meas_frame;
              match_nx = '0;
            end
          end
        end
        LOCKED: begin
          if ((hs_fall && meas_len != line_len) ||
              (vs_fall &&
               meas_frame != frame_lines)) begin
            err_nx   = 1'b1;
            state_nx = MEASURE;
            match_nx = '0;
            if (hs_fall) line_nx = meas_len;
            if (vs_fall) frame_nx = meas_frame;
          end
        end
        default: state_nx = SEARCH;
      endcase
      if (h_nx == CNT_MAX || v_nx == CNT_MAX) begin
        state_nx = SEARCH;
        match_nx = '0;
        err_nx   = (state == LOCKED);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= SEARCH;
      h_cnt       <= '0;
      v_cnt       <= '0;
      line_len    <= '0;
      frame_lines <= '0;
      first_len   <= '0;
      first_seen  <= 1'b0;
      line_bad    <= 1'b0;
      match_cnt   <= '0;
      err         <= 1'b0;
    end else begin
      state       <= state_nx;
      h_cnt       <= h_nx;
      v_cnt       <= v_nx;
      line_len    <= line_nx;
      frame_lines <= frame_nx;
      first_len   <= first_nx;
      first_seen  <= seen_nx;
      line_bad    <= bad_nx;
      match_cnt   <= match_nx;
      err         <= err_nx;
    end
  end

  assign hact = (h_cnt >= H_LO) && (h_cnt < H_HI);
  assign vact = (v_cnt >= V_LO) && (v_cnt < V_HI);

  assign o_locked = (state == LOCKED);
  assign o_active = o_locked & hact & vact;
  assign o_x = o_active ? 10'(h_cnt - H_LO) : '0;
  assign o_y = o_active ? 10'(v_cnt - V_LO) : '0;
  assign o_line_len    = line_len;
  assign o_frame_lines = frame_lines;
  assign o_err         = err;

endmodule

// File: doc/vga_sync_monitor.md
Name: vga_sync_monitor

Overview:
- Receive-side counterpart of the VGA timing generator.
- Consumes active-low HS/VS (plus the pixel strobe) as emitted by the generator, measures line length and frame height, and locks once the timing is stable.
- Recovers pixel coordinates and an active-area flag, and flags timing changes or loss of sync.
- Sits beside the display path as a self-check / loopback monitor and as the coordinate source for downstream pixel consumers.

Parameters:
- HS_TO_ACTIVE, 144, pixel strobes from HS falling edge to first active pixel (sync 96 + back porch 48)
- H_ACTIVE, 640, active pixels per line
- VS_TO_ACTIVE, 35, HS falling edges counted after VS falling edge before first active line
- V_ACTIVE, 480, active lines per frame
- LOCK_FRAMES, 2, consecutive matching frames required to assert lock (1..7)

Ports:
- clk  in  1  base clock
- rst  in  1  synchronous, active-high reset
- pix_en  in  1  pixel strobe; all sampling and counting occurs only on clk edges with pix_en=1
- i_hs  in  1  horizontal sync, active low
- i_vs  in  1  vertical sync, active low
- o_locked  out  1  timing stable
- o_active  out  1  current pixel inside active area (only while locked)
- o_x  out  10  recovered x, 0 when not active
- o_y  out  10  recovered y, 0 when not active
- o_line_len  out  11  reference line length in pixel strobes
- o_frame_lines  out  11  reference HS count per frame
- o_err  out  1  one-clk pulse on lock loss or timeout

Behaviour:
- Reset: state=SEARCH; counters, references and match_cnt = 0. All outputs 0. i_hs/i_vs history registers = 1 (idle).
- Edges:
  - hs_fall = pix_en & prev_hs & ~i_hs.
  - vs_fall likewise.
  - prev_* updates only on pix_en.
- h_cnt (11b):
  - Set to 0 on hs_fall.
  - Otherwise +1 per strobe, saturating at 2047.
  - Measured line length = h_cnt+1 at hs_fall.
- v_cnt (11b):
  - +1 on hs_fall, saturating at 2047.
  - On vs_fall: measured frame_lines = v_cnt, then v_cnt <= 0.
  - vs_fall and hs_fall on the same strobe: the HS edge counts into the ending frame (meas = v_cnt+1), and v_cnt <= 0.
- line_bad flag:
  - Set when any hs_fall in the current frame measures a length different from the first line of that frame.
  - Cleared on vs_fall.
- FSM:
  - SEARCH: on vs_fall -> MEASURE; clear line_bad, match_cnt.
  - MEASURE:
    - At each vs_fall, a frame is good if line_bad=0 and the measured length equals the latched line length.
    - Good frame: if frame_lines equals the latched reference, match_cnt+1; else reload the references and set match_cnt=0.
    - Bad frame: reload the references and set match_cnt=0.
    - match_cnt reaching LOCK_FRAMES-1 on a good vs_fall -> LOCKED.
  - LOCKED:
    - Any hs_fall length != o_line_len, or vs_fall frame_lines != o_frame_lines -> o_err pulse, -> MEASURE with the new measurement as reference, match_cnt=0.
  - Any state: h_cnt or v_cnt reaching 2047 (timeout) -> SEARCH; o_err pulses if leaving LOCKED.
- Coordinates (combinational from registered counters, valid the clk after the strobe):
  - hact = h_cnt in [HS_TO_ACTIVE, HS_TO_ACTIVE+H_ACTIVE).
  - vact = v_cnt in [VS_TO_ACTIVE, VS_TO_ACTIVE+V_ACTIVE).
  - o_active = o_locked & hact & vact.
  - o_x = h_cnt-HS_TO_ACTIVE and o_y = v_cnt-VS_TO_ACTIVE when active, else 0.
- o_line_len / o_frame_lines hold the latched reference; they are 0 until the first reference is taken.
- pix_en low: all state holds. rst mid-frame returns to the reset state on the next clk regardless of pix_en.

Decomposition:
- Shared package vga_pkg:
  - 640x480 timing constants (HS/VS widths, porches, totals).
  - FSM state enum {SEARCH, MEASURE, LOCKED}.
  - Counter width constant (11).
- One sub-module, sync_edge_det: strobe-qualified falling-edge detector, instantiated for HS and VS.

Test Plan:
- Reset then drive standard 800x525 timing (pix_en every other clk) -> o_locked=0 in the first frame; o_locked=1 after the 2nd matching vs_fall; o_line_len=800, o_frame_lines=525.
- Locked, observe strobe 144 after HS fall on line 35 after VS -> o_active=1, o_x=0, o_y=0; strobe 783 on line 514 -> o_x=639, o_y=479; strobe 784 -> o_active=0, o_x=0.
- Locked, switch to 801-pixel lines mid-frame -> o_err single-clk pulse at the first 801 hs_fall, o_locked=0, relock after 2 clean 801x525 frames with o_line_len=801.
- Hold i_hs high for 2048 strobes while locked -> o_err pulse, state SEARCH, o_locked=0.
- Stop pix_en for 1000 clks mid-line -> counters, o_x, o_locked unchanged; resume continues without error.
- Assert rst while locked mid-frame -> next clk: all outputs 0; relock requires a new VS then 2 matching frames.
